exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage LA32 pipeline, between the ID stage and the MEM stage.
//  - Registers the ID->EX bus.
//  - Computes ALU/multiply results through the shared alu block.
//  - Runs div.w/div.wu/mod.w/mod.wu on a multi-cycle iterative divider.
//  - Issues data SRAM requests.
//  - Returns write-back/hazard feedback to the ID stage.
// PARAMETERS
//  DIV_CYCLES  32  divider iterations; start to done = DIV_CYCLES+1 clk
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high
//  ms_allowin      in   1    MEM stage can accept
//  es_allowin      out  1    EX stage can accept
//  ds_to_es_valid  in   1    ID bus valid
//  ds_to_es_bus    in   157  {div_op[156:153],alu_op[152:138],load_op,src1_is_pc,src2_is_imm,
//                            gr_we,mem_we,dest[132:128],imm[127:96],rj[95:64],rkd[63:32],pc[31:0]}
//  es_to_ms_valid  out  1    EX->MEM valid
//  es_to_ms_bus    out  71   {res_from_mem[70],gr_we[69],dest[68:64],result[63:32],pc[31:0]}
//  es_to_ds_bus    out  39   {es_we[38],es_dest[37:33],es_result[32:1],es_blk[0]}
//  data_sram_en    out  1    data SRAM enable
//  data_sram_wen   out  4    byte write enables
//  data_sram_addr  out  32   ALU result
//  data_sram_wdata out  32   rkd
// BEHAVIOUR
//  - Reset (sync): es_valid=0, div busy=0, div done=0, counter=0.
//    Resulting outputs: es_to_ms_valid=0, es_we=0, es_blk=0, data_sram_wen=0, es_allowin=1.
//  - Capture: bus register loads when ds_to_es_valid && es_allowin.
//    es_valid <= ds_to_es_valid whenever es_allowin.
//  - Handshake:
//    es_ready_go = !is_div || div_done
//    es_allowin = !es_valid || (es_ready_go && ms_allowin)
//    es_to_ms_valid = es_valid && es_ready_go
//  - Operands: src1 = src1_is_pc ? pc : rj; src2 = src2_is_imm ? imm : rkd.
//    Non-div ops take 1 cycle (alu, incl. mul/mulh/mulhu).
//  - is_div = |div_op. Encoding: [0] div.w, [1] div.wu, [2] mod.w, [3] mod.wu.
//  - Divider FSM: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE->BUSY when es_valid && is_div && !div_done.
//      Latch |rj| and |rkd| (magnitudes only for signed ops). Counter=0.
//    BUSY: one restoring-subtract step per clk. After DIV_CYCLES steps -> DONE.
//    DONE: apply sign fix-up. Quotient negative iff operand signs differ (signed ops).
//      Remainder takes the dividend's sign.
//      Hold the result until es_to_ms_valid && ms_allowin, then -> IDLE.
//    A back-to-back div in the next instruction restarts from IDLE on the following clk.
//  - Divide by zero: result is unspecified, but latency stays fixed at DIV_CYCLES+1.
//    The FSM never hangs.
//  - Overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
//  - es_result = is_div ? (mod ? rem : quot) : alu_result.
//  - es_we = es_valid && gr_we; es_dest = dest.
//  - es_blk = es_valid && (load_op || (is_div && !div_done)).
//    ID stalls on this bit when dest matches.
//  - Memory: data_sram_en = 1. data_sram_wen = (es_valid && mem_we) ? 4'hf : 4'h0.
//    addr = alu_result; wdata = rkd.
//  - Reset mid-divide: FSM aborts to IDLE. No stale done is left behind.
//  - Cancellation: none. ID resolves branches, so EX never receives wrong-path work.
// STRUCTURE
//  - mycpu.h: DS_TO_ES_BUS_WD=157, ES_TO_MS_BUS_WD=71, ES_TO_DS_BUS_WD=39, div_op bit indices.
//  - Sub-module exe_div_iter: clk, reset, start, signed, dividend, divisor -> busy, done, quot, rem.
//    Contains the FSM and counter.
//  - The alu block is reused unchanged.
// TESTING
//  1. add.w rj=5 rkd=7, ms_allowin=1 -> es_to_ms_valid the cycle after capture, result=12, es_blk=0.
//  2. div.w rj=-7 rkd=2 -> es_blk=1 and es_allowin=0 for 33 clk.
//     Then result=0xFFFFFFFD. mod.w of the same operands -> 0xFFFFFFFF.
//  3. div.wu rj=0xFFFFFFFF rkd=0x10 -> 0x0FFFFFFF.
//     Hold ms_allowin=0 for 5 clk after done -> result stable, no restart.
//  4. st.w rj=0x1000 imm=8 rkd=0xAA -> wen=4'hf, addr=0x1008, wdata=0xAA.
//     ld.w to r4 -> es_blk=1, es_dest=4.
//  5. Assert reset 10 clk into a div.wu -> all outputs at reset values.
//     Next div completes normally in 33 clk.
//  6. div.w by zero, then 0x80000000/-1 -> both done in 33 clk.
//     The second gives quotient 0x80000000.

Source files
------------

// File: rtl/exe_stage_pkg.sv
`timescale 1ns/1ps
// Shared widths, bus layouts, opcode bit positions and divider state for the LA32 EX stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 157;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_DS_BUS_WD = 39;

  // div_op bit positions
  localparam int DIV_W  = 0;
  localparam int DIV_WU = 1;
  localparam int MOD_W  = 2;
  localparam int MOD_WU = 3;

  // alu_op one-hot bit positions
  localparam int ALU_OP_W  = 15;
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLT   = 2;
  localparam int ALU_SLTU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_NOR   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_XOR   = 7;
  localparam int ALU_SLL   = 8;
  localparam int ALU_SRL   = 9;
  localparam int ALU_SRA   = 10;
  localparam int ALU_LUI   = 11;
  localparam int ALU_MUL   = 12;
  localparam int ALU_MULH  = 13;
  localparam int ALU_MULHU = 14;

  typedef struct packed {
    logic [3:0]          div_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic                load_op;
    logic                src1_is_pc;
    logic                src2_is_imm;
    logic                gr_we;
    logic                mem_we;
    logic [4:0]          dest;
    logic [31:0]         imm;
    logic [31:0]         rj;
    logic [31:0]         rkd;
    logic [31:0]         pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/alu.sv
`timescale 1ns/1ps
// Single-cycle ALU with one-hot op select, including 32x32 multiply (low, signed high, unsigned high).
module alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [31:0]         src1_i,
  input  logic [31:0]         src2_i,
  output logic [31:0]         result_o
);

  logic [31:0]        add_sub;
  logic [31:0]        slt_res;
  logic [31:0]        sltu_res;
  logic [31:0]        sll_res;
  logic [31:0]        srl_res;
  logic [31:0]        sra_res;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] prod;
  logic               unused_prod_top;

  assign add_sub  = alu_op_i[ALU_SUB] ? (src1_i - src2_i) : (src1_i + src2_i);
  assign slt_res  = {31'd0, ($signed(src1_i) < $signed(src2_i))};
  assign sltu_res = {31'd0, (src1_i < src2_i)};
  assign sll_res  = src1_i << src2_i[4:0];
  assign srl_res  = src1_i >> src2_i[4:0];
  assign sra_res  = $unsigned($signed(src1_i) >>> src2_i[4:0]);

  // One extra operand bit lets a single signed multiplier serve both mulh and mulhu.
  assign mul_a = {alu_op_i[ALU_MULH] & src1_i[31], src1_i};
  assign mul_b = {alu_op_i[ALU_MULH] & src2_i[31], src2_i};
  assign prod  = 66'(mul_a) * 66'(mul_b);
  assign unused_prod_top = ^prod[65:64];

  assign result_o = ({32{alu_op_i[ALU_ADD] | alu_op_i[ALU_SUB]}} & add_sub)
                  | ({32{alu_op_i[ALU_SLT]}}   & slt_res)
                  | ({32{alu_op_i[ALU_SLTU]}}  & sltu_res)
                  | ({32{alu_op_i[ALU_AND]}}   & (src1_i & src2_i))
                  | ({32{alu_op_i[ALU_NOR]}}   & ~(src1_i | src2_i))
                  | ({32{alu_op_i[ALU_OR]}}    & (src1_i | src2_i))
                  | ({32{alu_op_i[ALU_XOR]}}   & (src1_i ^ src2_i))
                  | ({32{alu_op_i[ALU_SLL]}}   & sll_res)
                  | ({32{alu_op_i[ALU_SRL]}}   & srl_res)
                  | ({32{alu_op_i[ALU_SRA]}}   & sra_res)
                  | ({32{alu_op_i[ALU_LUI]}}   & src2_i)
                  | ({32{alu_op_i[ALU_MUL]}}   & prod[31:0])
                  | ({32{alu_op_i[ALU_MULH] | alu_op_i[ALU_MULHU]}} & prod[63:32]);

endmodule

// File: rtl/exe_div_iter.sv
`timescale 1ns/1ps
// Iterative restoring divider on operand magnitudes; signs are re-applied to quotient and remainder in DONE.
module exe_div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic [32:0]   trial;
  logic          fits;
  logic [31:0]   rem_step;

  // Shift the next dividend bit into the partial remainder and subtract if the divisor fits.
  assign trial    = {rem_q, quo_q[31]};
  assign fits     = (trial >= {1'b0, dvs_q});
  assign rem_step = fits ? (trial[31:0] - dvs_q) : trial[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d   = DIV_BUSY;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = mag32(dividend_i, signed_i);
          dvs_d     = mag32(divisor_i, signed_i);
          neg_quo_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
          neg_rem_d = signed_i && dividend_i[31];
        end
      end
      DIV_BUSY: begin
        rem_d = rem_step;
        quo_d = {quo_q[30:0], fits};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (ack_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // busy/done together expose the FSM state (neither set means IDLE).
  assign busy_o = (state_q == DIV_BUSY);
  assign done_o = (state_q == DIV_DONE);
  assign quot_o = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_o  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
`timescale 1ns/1ps
// LA32 execute stage: registers the ID->EX bus, runs ALU or iterative divide, drives data SRAM and ID feedback.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_to_es_t   es_bus_q, es_bus_d;
  logic        es_valid_q, es_valid_d;

  logic        es_ready_go;
  logic        is_div;
  logic        div_signed;
  logic        is_mod;
  logic        div_start;
  logic        div_ack;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic [31:0] es_result;
  logic        es_we;
  logic        es_blk;

  // Handshake: a stage holds its instruction while valid && !ready_go; a transfer to MEM
  // happens on the clk where es_to_ms_valid && ms_allowin, and a new ID instruction is
  // captured whenever es_allowin (empty, or the current one leaves this same clk).
  assign is_div         = |es_bus_q.div_op;
  assign es_ready_go    = !is_div || div_done;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
    end
  end

  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_bus_d = ds_to_es_t'(ds_to_es_bus);
      end
    end
  end

  assign src1 = es_bus_q.src1_is_pc  ? es_bus_q.pc  : es_bus_q.rj;
  assign src2 = es_bus_q.src2_is_imm ? es_bus_q.imm : es_bus_q.rkd;

  alu u_alu (
    .alu_op_i (es_bus_q.alu_op),
    .src1_i   (src1),
    .src2_i   (src2),
    .result_o (alu_result)
  );

  assign div_signed = es_bus_q.div_op[DIV_W] | es_bus_q.div_op[MOD_W];
  assign is_mod     = es_bus_q.div_op[MOD_W] | es_bus_q.div_op[MOD_WU];
  assign div_start  = es_valid_q && is_div && !div_done && !div_busy;
  assign div_ack    = es_to_ms_valid && ms_allowin;

  exe_div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .signed_i   (div_signed),
    .dividend_i (es_bus_q.rj),
    .divisor_i  (es_bus_q.rkd),
    .ack_i      (div_ack),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  assign es_result = is_div ? (is_mod ? div_rem : div_quot) : alu_result;
  assign es_we     = es_valid_q && es_bus_q.gr_we;
  // Loads and unfinished divides cannot forward a value yet, so ID must stall on a dest match.
  assign es_blk    = es_valid_q && (es_bus_q.load_op || (is_div && !div_done));

  assign es_to_ms_bus = {es_bus_q.load_op, es_bus_q.gr_we, es_bus_q.dest, es_result, es_bus_q.pc};
  assign es_to_ds_bus = {es_we, es_bus_q.dest, es_result, es_blk};

  assign data_sram_en    = 1'b1;
  assign data_sram_wen   = (es_valid_q && es_bus_q.mem_we) ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_q.rkd;

endmodule

// File: tb/tb_exe_stage.sv
`timescale 1ns/1ps
// Directed bench for exe_stage: table of single-cycle ALU vectors plus hand sequences for divide, memory and reset.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [156:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_vec = 0;
  int n_err = 0;

  exe_stage #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_bus    (es_to_ds_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        ms_res_from_mem, ms_gr_we, es_we, es_blk;
  logic [4:0]  ms_dest, es_dest;
  logic [31:0] ms_result, ms_pc, es_result;
  assign ms_res_from_mem = es_to_ms_bus[70];
  assign ms_gr_we        = es_to_ms_bus[69];
  assign ms_dest         = es_to_ms_bus[68:64];
  assign ms_result       = es_to_ms_bus[63:32];
  assign ms_pc           = es_to_ms_bus[31:0];
  assign es_we           = es_to_ds_bus[38];
  assign es_dest         = es_to_ds_bus[37:33];
  assign es_result       = es_to_ds_bus[32:1];
  assign es_blk          = es_to_ds_bus[0];

  typedef struct {
    int          op;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] imm;
    logic        s1pc;
    logic        s2imm;
    logic [31:0] pc;
    logic [31:0] exp;
  } alu_vec_t;

  localparam int NV = 17;
  alu_vec_t tbl [NV];

  function automatic logic [156:0] mk_bus(
    input logic [3:0]  dop,
    input logic [14:0] aop,
    input logic        ld,
    input logic        s1pc,
    input logic        s2imm,
    input logic        we,
    input logic        mwe,
    input logic [4:0]  dst,
    input logic [31:0] imm,
    input logic [31:0] rj,
    input logic [31:0] rkd,
    input logic [31:0] pc
  );
    return {dop, aop, ld, s1pc, s2imm, we, mwe, dst, imm, rj, rkd, pc};
  endfunction

  // scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [156:0] bus);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    step();
    ds_to_es_valid = 1'b0;
  endtask

  // Called right after a div is captured; counts stalled clocks until es_to_ms_valid rises.
  task automatic wait_done(input string name, input int exp_cycles);
    int cyc = 0;
    int blk = 0;
    int stall = 0;
    while (!es_to_ms_valid && cyc < 100) begin
      if (es_blk) blk++;
      if (!es_allowin) stall++;
      cyc++;
      step();
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_cycles));
    check({name, " blk clks"}, 32'(blk), 32'(exp_cycles));
    check({name, " stall clks"}, 32'(stall), 32'(exp_cycles));
  endtask

  task automatic div_case(input string name, input logic [3:0] dop, input logic [31:0] a,
                          input logic [31:0] b, input logic chk, input logic [31:0] exp);
    issue(mk_bus(dop, 15'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'd0, a, b, 32'h1c00_0100));
    wait_done(name, 33);
    if (chk) check({name, " result"}, ms_result, exp);
  endtask

  task automatic drain(input string name);
    ds_to_es_valid = 1'b0;
    ms_allowin     = 1'b1;
    step();
    check({name, " drained valid"}, 32'(es_to_ms_valid), 32'd0);
    check({name, " drained allowin"}, 32'(es_allowin), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{ALU_ADD,   32'd5,          32'd7,          32'd0,          1'b0, 1'b0, 32'h0,         32'd12};
    tbl[1]  = '{ALU_SUB,   32'd5,          32'd7,          32'd0,          1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE};
    tbl[2]  = '{ALU_SLT,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 32'h0,         32'd1};
    tbl[3]  = '{ALU_SLTU,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 32'h0,         32'd0};
    tbl[4]  = '{ALU_AND,   32'h0000_F0F0,  32'h0000_FF00,  32'd0,          1'b0, 1'b0, 32'h0,         32'h0000_F000};
    tbl[5]  = '{ALU_OR,    32'h0000_F0F0,  32'h0000_FF00,  32'd0,          1'b0, 1'b0, 32'h0,         32'h0000_FFF0};
    tbl[6]  = '{ALU_NOR,   32'd0,          32'd0,          32'd0,          1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF};
    tbl[7]  = '{ALU_XOR,   32'h0000_00FF,  32'h0000_000F,  32'd0,          1'b0, 1'b0, 32'h0,         32'h0000_00F0};
    tbl[8]  = '{ALU_SLL,   32'd1,          32'd31,         32'd0,          1'b0, 1'b0, 32'h0,         32'h8000_0000};
    tbl[9]  = '{ALU_SRL,   32'h8000_0000,  32'd4,          32'd0,          1'b0, 1'b0, 32'h0,         32'h0800_0000};
    tbl[10] = '{ALU_SRA,   32'h8000_0000,  32'd4,          32'd0,          1'b0, 1'b0, 32'h0,         32'hF800_0000};
    tbl[11] = '{ALU_LUI,   32'd0,          32'd0,          32'h1234_5000,  1'b0, 1'b1, 32'h0,         32'h1234_5000};
    tbl[12] = '{ALU_MUL,   32'hFFFF_FFFE,  32'd3,          32'd0,          1'b0, 1'b0, 32'h0,         32'hFFFF_FFFA};
    tbl[13] = '{ALU_MULH,  32'hFFFF_FFFE,  32'd3,          32'd0,          1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF};
    tbl[14] = '{ALU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE};
    tbl[15] = '{ALU_ADD,   32'd0,          32'd0,          32'd4,          1'b1, 1'b1, 32'h1c00_0000, 32'h1c00_0004};
    tbl[16] = '{ALU_ADD,   32'h0000_1000,  32'd0,          32'd8,          1'b0, 1'b1, 32'h0,         32'h0000_1008};

    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (3) step();
    check("reset es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    check("reset es_we", 32'(es_we), 32'd0);
    check("reset es_blk", 32'(es_blk), 32'd0);
    check("reset wen", 32'(data_sram_wen), 32'd0);
    check("reset es_allowin", 32'(es_allowin), 32'd1);
    check("reset sram_en", 32'(data_sram_en), 32'd1);
    reset = 1'b0;
    step();

    // Single-cycle ALU vectors, issued back to back.
    for (int i = 0; i < NV; i++) begin
      issue(mk_bus(4'd0, 15'(1) << tbl[i].op, 1'b0, tbl[i].s1pc, tbl[i].s2imm, 1'b1, 1'b0,
                   5'(i + 1), tbl[i].imm, tbl[i].rj, tbl[i].rkd, tbl[i].pc));
      check($sformatf("alu%0d valid", i), 32'(es_to_ms_valid), 32'd1);
      check($sformatf("alu%0d result", i), ms_result, tbl[i].exp);
      check($sformatf("alu%0d fwd result", i), es_result, tbl[i].exp);
      check($sformatf("alu%0d blk", i), 32'(es_blk), 32'd0);
      check($sformatf("alu%0d dest", i), 32'(ms_dest), 32'(i + 1));
      check($sformatf("alu%0d addr", i), data_sram_addr, tbl[i].exp);
    end
    drain("alu");

    // Signed divide then back-to-back mod of the same operands.
    div_case("div.w -7/2", 4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
    div_case("mod.w -7%2", 4'b0100, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    drain("div.w");

    // Unsigned divide held at done by MEM backpressure.
    div_case("div.wu", 4'b0010, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF);
    ms_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d valid", i), 32'(es_to_ms_valid), 32'd1);
      check($sformatf("hold%0d result", i), ms_result, 32'h0FFF_FFFF);
      check($sformatf("hold%0d allowin", i), 32'(es_allowin), 32'd0);
      check($sformatf("hold%0d blk", i), 32'(es_blk), 32'd0);
    end
    drain("hold");

    // Store then load.
    issue(mk_bus(4'd0, 15'(1) << ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,
                 32'd8, 32'h0000_1000, 32'h0000_00AA, 32'h1c00_0200));
    check("st.w wen", 32'(data_sram_wen), 32'hf);
    check("st.w addr", data_sram_addr, 32'h0000_1008);
    check("st.w wdata", data_sram_wdata, 32'h0000_00AA);
    check("st.w es_we", 32'(es_we), 32'd0);
    issue(mk_bus(4'd0, 15'(1) << ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4,
                 32'd0, 32'h0000_2000, 32'd0, 32'h1c00_0204));
    check("ld.w blk", 32'(es_blk), 32'd1);
    check("ld.w dest", 32'(es_dest), 32'd4);
    check("ld.w from_mem", 32'(ms_res_from_mem), 32'd1);
    check("ld.w wen", 32'(data_sram_wen), 32'h0);
    check("ld.w es_we", 32'(es_we), 32'd1);
    check("ld.w pc", ms_pc, 32'h1c00_0204);
    drain("ld.w");

    // Reset 10 clk into a divide, then a clean divide.
    issue(mk_bus(4'b0010, 15'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'd0, 32'd100, 32'd7, 32'h0));
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    check("midrst es_we", 32'(es_we), 32'd0);
    check("midrst es_blk", 32'(es_blk), 32'd0);
    check("midrst wen", 32'(data_sram_wen), 32'd0);
    check("midrst es_allowin", 32'(es_allowin), 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (es_to_ms_valid) check($sformatf("post-reset idle clk%0d valid", i), 32'(es_to_ms_valid), 32'd0);
    end
    div_case("div.wu 100/7", 4'b0010, 32'd100, 32'd7, 1'b1, 32'd14);
    div_case("mod.wu 100%7", 4'b1000, 32'd100, 32'd7, 1'b1, 32'd2);
    drain("after reset");

    // Divide by zero keeps fixed latency; signed overflow case.
    div_case("div.w by 0", 4'b0001, 32'd5, 32'd0, 1'b0, 32'd0);
    div_case("div.w ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    div_case("mod.w ovf", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0);
    drain("ovf");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
